// File: rtl/riscv_multiciclo_controle.sv
// ============================================================================
// riscv_multiciclo_controle
//   Multicycle RV32I control unit: Moore FSM, datapath selects, instret counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_multiciclo_controle (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  state,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instret_q;

  logic pc_write, mem_write, ir_write, reg_write, retire_c, illegal_c;
  logic taken, branch_ok;

  always_comb begin
    taken     = 1'b0;
    branch_ok = 1'b1;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: branch_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire_c   = 1'b0;
    illegal_c  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        retire_c  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        if (funct3 == 3'b000) begin
          ALUControl = funct7b5 ? ALU_SUB : ALU_ADD;
          state_d    = S_ALUWB;
        end else begin
          state_d    = S_ILLEGAL;
        end
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (funct3 == 3'b000) ? S_ALUWB : S_ILLEGAL;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_write   = branch_ok & taken;
        retire_c   = branch_ok;
        state_d    = branch_ok ? S_FETCH : S_ILLEGAL;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_c = 1'b1;
      end
      default: state_d = S_ILLEGAL;
    endcase
  end

  // Reset masks side effects in the same time step, even though FETCH is
  // otherwise sensitive to mem_ready.
  assign PCWrite  = pc_write  & reset;
  assign IRWrite  = ir_write  & reset;
  assign MemWrite = mem_write & reset;
  assign RegWrite = reg_write & reset;
  assign retire   = retire_c  & reset;
  assign illegal  = illegal_c & reset;
  assign state    = state_q;
  assign instret  = instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_multiciclo_controle.sv
// ============================================================================
// tb_riscv_multiciclo_controle
//   Directed-vector bench for the multicycle RV32I control unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscv_multiciclo_controle;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero, lt, ltu, mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  riscv_multiciclo_controle dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .state      (state),
    .retire     (retire),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    #1;
  endtask

  function automatic logic [4:0] enables();
    return {PCWrite, IRWrite, MemWrite, RegWrite, retire};
  endfunction

  // Branch table: funct3, zero, lt, ltu, expected PCWrite
  logic [2:0] br_f3  [4] = '{3'b001, 3'b001, 3'b110, 3'b101};
  logic       br_z   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic       br_lt  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       br_ltu [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       br_pcw [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0);
    #2;
    check("rst_state",   32'(state), 32'd0);
    check("rst_enables", 32'(enables()), 32'd0);
    check("rst_instret", instret, 32'd0);
    tick();
    check("rst_hold_state", 32'(state), 32'd0);
    check("rst_hold_irw",   32'(IRWrite), 32'd0);

    // release: first FETCH happens on the very next edge
    reset = 1'b1; #1;
    check("fetch_irw",  32'(IRWrite), 32'd1);
    check("fetch_pcw",  32'(PCWrite), 32'd1);
    check("fetch_srcb", 32'(ALUSrcB), 32'd2);
    check("fetch_res",  32'(ResultSrc), 32'd2);

    // add x3,x1,x2
    set_instr(OP_R, 3'b000, 1'b0);
    tick();
    check("add_s1",   32'(state), 32'd1);
    check("dec_srca", 32'(ALUSrcA), 32'd1);
    check("dec_srcb", 32'(ALUSrcB), 32'd1);
    tick();
    check("add_s6",   32'(state), 32'd6);
    check("add_alu",  32'(ALUControl), 32'd0);
    check("add_rw6",  32'(RegWrite), 32'd0);
    check("add_srca", 32'(ALUSrcA), 32'd2);
    tick();
    check("add_s8",   32'(state), 32'd8);
    check("add_rw8",  32'(RegWrite), 32'd1);
    check("add_ret",  32'(retire), 32'd1);
    check("add_ir0",  instret, 32'd0);
    tick();
    check("add_s0",   32'(state), 32'd0);
    check("add_ir1",  instret, 32'd1);

    // sub
    set_instr(OP_R, 3'b000, 1'b1);
    tick(); tick();
    check("sub_alu", 32'(ALUControl), 32'd1);
    tick(); tick();
    check("sub_ir2", instret, 32'd2);

    // FETCH stall
    mem_ready = 1'b0; #1;
    check("stall_irw", 32'(IRWrite), 32'd0);
    check("stall_pcw", 32'(PCWrite), 32'd0);
    tick();
    check("stall_state", 32'(state), 32'd0);
    mem_ready = 1'b1;

    // lw with 3 wait cycles in MEMREAD
    set_instr(OP_LOAD, 3'b010, 1'b0);
    tick();
    check("lw_imm", 32'(ImmSrc), 32'd0);
    tick();
    check("lw_s2", 32'(state), 32'd2);
    tick();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_s3", 32'(state), 32'd3);
      check("lw_wait_rw", 32'(RegWrite), 32'd0);
      check("lw_wait_adr", 32'(AdrSrc), 32'd1);
      check("lw_wait_ret", 32'(retire), 32'd0);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("lw_s3_last", 32'(state), 32'd3);
    tick();
    check("lw_s4",  32'(state), 32'd4);
    check("lw_res", 32'(ResultSrc), 32'd1);
    check("lw_rw",  32'(RegWrite), 32'd1);
    check("lw_ret", 32'(retire), 32'd1);
    tick();
    check("lw_ir3", instret, 32'd3);

    // sw with one wait cycle
    set_instr(OP_STORE, 3'b010, 1'b0);
    tick();
    check("sw_imm", 32'(ImmSrc), 32'd1);
    tick(); tick();
    mem_ready = 1'b0; #1;
    check("sw_s5",    32'(state), 32'd5);
    check("sw_mw",    32'(MemWrite), 32'd1);
    check("sw_ret0",  32'(retire), 32'd0);
    tick();
    mem_ready = 1'b1; #1;
    check("sw_mw2",   32'(MemWrite), 32'd1);
    check("sw_ret1",  32'(retire), 32'd1);
    tick();
    check("sw_s0",  32'(state), 32'd0);
    check("sw_ir4", instret, 32'd4);

    // branches
    for (int i = 0; i < 4; i++) begin
      set_instr(OP_BRANCH, br_f3[i], 1'b0);
      zero = br_z[i]; lt = br_lt[i]; ltu = br_ltu[i]; #1;
      tick();
      check("br_imm", 32'(ImmSrc), 32'd2);
      tick();
      check("br_s9",  32'(state), 32'd9);
      check("br_pcw", 32'(PCWrite), 32'(br_pcw[i]));
      check("br_ret", 32'(retire), 32'd1);
      check("br_alu", 32'(ALUControl), 32'd1);
      tick();
      check("br_s0",  32'(state), 32'd0);
    end
    check("br_ir8", instret, 32'd8);
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;

    // jal
    set_instr(OP_JAL, 3'b000, 1'b0);
    tick();
    check("jal_imm", 32'(ImmSrc), 32'd3);
    tick();
    check("jal_s10",  32'(state), 32'd10);
    check("jal_pcw",  32'(PCWrite), 32'd1);
    check("jal_srca", 32'(ALUSrcA), 32'd1);
    check("jal_srcb", 32'(ALUSrcB), 32'd2);
    check("jal_rw",   32'(RegWrite), 32'd0);
    tick();
    check("jal_s8",  32'(state), 32'd8);
    check("jal_ret", 32'(retire), 32'd1);
    tick();
    check("jal_ir9", instret, 32'd9);

    // addi
    set_instr(OP_IMM, 3'b000, 1'b0);
    tick(); tick();
    check("addi_s7",   32'(state), 32'd7);
    check("addi_srcb", 32'(ALUSrcB), 32'd1);
    tick();
    check("addi_s8", 32'(state), 32'd8);
    tick();
    check("addi_ir10", instret, 32'd10);

    // instret wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    check("wrap_pre", instret, 32'hFFFF_FFFF);
    set_instr(OP_R, 3'b000, 1'b0);
    tick(); tick(); tick(); tick();
    check("wrap_post", instret, 32'd0);
    check("wrap_s0",   32'(state), 32'd0);

    // reset mid-MEMWRITE
    set_instr(OP_R, 3'b000, 1'b0);
    tick(); tick(); tick(); tick();
    check("pre_sw_ir1", instret, 32'd1);
    set_instr(OP_STORE, 3'b010, 1'b0);
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("msw_mw1", 32'(MemWrite), 32'd1);
    reset = 1'b0; #1;
    check("msw_mw0",     32'(MemWrite), 32'd0);
    check("msw_state",   32'(state), 32'd0);
    check("msw_instret", instret, 32'd0);
    check("msw_enables", 32'(enables()), 32'd0);
    mem_ready = 1'b1;
    tick();
    reset = 1'b1; #1;
    check("msw_refetch", 32'(IRWrite), 32'd1);

    // branch with reserved funct3
    set_instr(OP_BRANCH, 3'b010, 1'b0);
    tick(); tick();
    check("bill_s9",  32'(state), 32'd9);
    check("bill_pcw", 32'(PCWrite), 32'd0);
    check("bill_ret", 32'(retire), 32'd0);
    tick();
    check("bill_s11", 32'(state), 32'd11);
    check("bill_ill", 32'(illegal), 32'd1);
    reset = 1'b0; #1;
    check("bill_clr", 32'(illegal), 32'd0);
    tick();
    reset = 1'b1;

    // R-type with unsupported funct3
    set_instr(OP_R, 3'b001, 1'b0);
    tick(); tick();
    check("rill_s6", 32'(state), 32'd6);
    check("rill_rw", 32'(RegWrite), 32'd0);
    tick();
    check("rill_s11", 32'(state), 32'd11);
    reset = 1'b0; #1;
    tick();
    reset = 1'b1;

    // unknown opcode is sticky
    set_instr(7'b1111111, 3'b000, 1'b0);
    tick();
    check("ill_s1", 32'(state), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("ill_state", 32'(state), 32'd11);
      check("ill_flag",  32'(illegal), 32'd1);
      check("ill_en",    32'(enables()), 32'd0);
      tick();
    end
    reset = 1'b0; #1;
    check("ill_rst_flag",  32'(illegal), 32'd0);
    check("ill_rst_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_multiciclo_controle.md
RISCV_MULTICICLO_CONTROLE -- requirements
Module: riscv_multiciclo_controle

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge; reset  in  1  asynchronous, active-low (0 = reset).
REQ-002 SHALL have inputs: op  in  7  Instr[6:0]; funct3  in  3  Instr[14:12]; funct7b5  in  1  Instr[30]; zero  in  1  ALU result==0; lt  in  1  signed rs1<rs2; ltu  in  1  unsigned rs1<rs2; mem_ready  in  1  memory access complete this cycle.
REQ-003 SHALL have outputs: PCWrite 1; AdrSrc 1 (0=PC, 1=ALUOut); MemWrite 1; IRWrite 1; RegWrite 1; ResultSrc 2 (00=ALUOut, 01=Data, 10=ALUResult); ALUSrcA 2 (00=PC, 01=OldPC, 10=RD1); ALUSrcB 2 (00=RD2, 01=ImmExt, 10=const 4); ALUControl 3 (000=add, 001=sub); ImmSrc 2 (00=I, 01=S, 10=B, 11=J); state 4; retire 1; illegal 1; instret 32.

Function
REQ-004 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, ILLEGAL=11; state output = current encoding.
REQ-005 SHALL drive ImmSrc combinationally from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
REQ-006 Unlisted control outputs SHALL be 0 in every state; ALUControl defaults to add.
REQ-007 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, else -> DECODE.
REQ-008 DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut <= branch/jump target); next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, other -> ILLEGAL.
REQ-009 MEMADR: ALUSrcA=10, ALUSrcB=01, add; -> MEMREAD if op=0000011, else MEMWRITE.
REQ-010 MEMREAD: AdrSrc=1; hold until mem_ready=1, then -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1, retire=1; -> FETCH.
REQ-011 MEMWRITE: AdrSrc=1, MemWrite=1 every cycle in state; hold until mem_ready=1, then retire=1, -> FETCH.
REQ-012 EXECR: ALUSrcA=10, ALUSrcB=00; ALUControl=sub if funct3=000 and funct7b5=1, add if funct3=000 and funct7b5=0; any other funct3 -> ILLEGAL next (no writes). Else -> ALUWB.
REQ-013 EXECI: ALUSrcA=10, ALUSrcB=01, add; funct3!=000 -> ILLEGAL, else -> ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegWrite=1, retire=1; -> FETCH.
REQ-015 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, retire=1; PCWrite=taken where taken = beq:zero, bne:~zero, blt:lt, bge:~lt, bltu:ltu, bgeu:~ltu; funct3 010/011 -> ILLEGAL with PCWrite=0, retire=0; else -> FETCH.
REQ-016 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; -> ALUWB (writes OldPC+4 to rd).
REQ-017 ILLEGAL: illegal=1, all write enables 0; sticky until reset.
REQ-018 instret SHALL increment by 1 (mod 2^32, wraps 0xFFFFFFFF->0) on each rising edge where retire=1.
REQ-019 Latency with mem_ready=1: R/I/JAL 4 cycles, lw 5, sw 4, branch 3 (FETCH to retire inclusive).

Reset
REQ-020 reset=0 SHALL immediately (asynchronously) force state=FETCH, instret=0, and all write enables (PCWrite, IRWrite, MemWrite, RegWrite) plus retire, illegal to 0, regardless of mem_ready, including mid-instruction.
REQ-021 First FETCH after reset release SHALL occur on the first rising edge with reset=1; no partial instruction resumes.

Verification
REQ-022 add x3,x1,x2 (op=0110011,f3=000,f7b5=0), mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8; instret 0->1.
REQ-023 lw with mem_ready=0 for 3 cycles in MEMREAD -> state 3 held 4 cycles, RegWrite stays 0 until MEMWB, retire pulses once.
REQ-024 bne with zero=1 -> BRANCH PCWrite=0, retire=1; with zero=0 -> PCWrite=1; bltu ltu=1 -> PCWrite=1.
REQ-025 op=1111111 -> DECODE -> ILLEGAL, illegal=1, held 10 cycles with no enables, cleared only by reset=0.
REQ-026 reset=0 asserted mid-MEMWRITE -> MemWrite drops same time step, state=0, instret=0; preload instret=0xFFFFFFFF via 2^32 retires (or force) -> next retire gives 0.
